// File: rtl/sprite_compositor_n_if.sv
// Sprite compositor bus: register/palette write port, pixel stream in,
// composited pixel stream and collision flags out.
interface sprite_compositor_n_if #(
  parameter int N_SPRITES = 8,
  parameter int SPR_SIZE  = 16,
  parameter int COORD_W   = 10,
  parameter int PAL_DEPTH = 16,
  parameter int COLOR_W   = 8
);
  localparam int SLOT_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int SEL_W  = $clog2(SPR_SIZE + 1);
  localparam int PAL_W  = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
  localparam int ATT_W  = 2 * COORD_W + PAL_W + 2;
  localparam int DATA_W = (ATT_W > SPR_SIZE) ? ATT_W : SPR_SIZE;

  logic                   wr_en;
  logic [SLOT_W-1:0]      wr_slot;
  logic [SEL_W-1:0]       wr_sel;
  logic [DATA_W-1:0]      wr_data;
  logic                   att_color;
  logic [PAL_W-1:0]       pal_addr;
  logic [3*COLOR_W-1:0]   data_color;
  logic                   coll_clr;
  logic                   pix_valid;
  logic [COORD_W-1:0]     row;
  logic [COORD_W-1:0]     column;
  logic [COLOR_W-1:0]     FIFO_Red;
  logic [COLOR_W-1:0]     FIFO_Green;
  logic [COLOR_W-1:0]     FIFO_Blue;
  logic [COLOR_W-1:0]     VGA_R;
  logic [COLOR_W-1:0]     VGA_G;
  logic [COLOR_W-1:0]     VGA_B;
  logic                   out_valid;
  logic [N_SPRITES-1:0]   collision;

  modport master (
    output wr_en, wr_slot, wr_sel, wr_data, att_color, pal_addr, data_color,
           coll_clr, pix_valid, row, column, FIFO_Red, FIFO_Green, FIFO_Blue,
    input  VGA_R, VGA_G, VGA_B, out_valid, collision
  );

  modport slave (
    input  wr_en, wr_slot, wr_sel, wr_data, att_color, pal_addr, data_color,
           coll_clr, pix_valid, row, column, FIFO_Red, FIFO_Green, FIFO_Blue,
    output VGA_R, VGA_G, VGA_B, out_valid, collision
  );
endinterface

// File: rtl/sprite_compositor_n.sv
// Three-stage sprite compositor: stage 1 per-slot hit test, stage 2 priority
// select and collision tracking, stage 3 palette lookup and optional blend.
module sprite_compositor_n #(
  parameter int N_SPRITES = 8,
  parameter int SPR_SIZE  = 16,
  parameter int COORD_W   = 10,
  parameter int PAL_DEPTH = 16,
  parameter int COLOR_W   = 8
) (
  input  logic clk_25,
  input  logic n_reset,
  sprite_compositor_n_if.slave bus
);
  localparam int SEL_W = $clog2(SPR_SIZE + 1);
  localparam int PAL_W = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
  localparam int OFF_W = $clog2(SPR_SIZE);
  localparam int CW1   = COORD_W + 1;
  localparam int RGB_W = 3 * COLOR_W;

  // Rounded-down mean of two channels, summed one bit wider so it never wraps
  function automatic logic [COLOR_W-1:0] avg(input logic [COLOR_W-1:0] a,
                                             input logic [COLOR_W-1:0] b);
    logic [COLOR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COLOR_W:1];
  endfunction

  // Sprite attributes, bitmaps and palette
  logic [N_SPRITES-1:0][COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [N_SPRITES-1:0][PAL_W-1:0]   pal_idx_q, pal_idx_d;
  logic [N_SPRITES-1:0]              en_q, en_d, mode_q, mode_d;
  logic [N_SPRITES-1:0][SPR_SIZE-1:0][SPR_SIZE-1:0] bmp_q, bmp_d;
  logic [PAL_DEPTH-1:0][RGB_W-1:0]   pal_q, pal_d;

  // Pipeline registers
  logic [N_SPRITES-1:0] hit_q, hit_d;
  logic [RGB_W-1:0]     bg1_q, bg1_d, bg2_q, bg2_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [PAL_W-1:0]     pal2_q, pal2_d;
  logic                 mode2_q, mode2_d, any2_q, any2_d;
  logic [N_SPRITES-1:0] collision_q, collision_d;
  logic [RGB_W-1:0]     rgb_q, rgb_d;
  logic                 out_valid_q, out_valid_d;

  // Stage temporaries
  logic             col_in, row_in, multi;
  logic [OFF_W-1:0] dx, dy;
  logic [RGB_W-1:0] pal_rgb;

  // Register and palette write decode; out-of-range selectors are dropped
  always_comb begin
    x_d = x_q; y_d = y_q; pal_idx_d = pal_idx_q; en_d = en_q; mode_d = mode_q;
    bmp_d = bmp_q; pal_d = pal_q;
    if (bus.wr_en && (32'(bus.wr_slot) < N_SPRITES)) begin
      if (bus.wr_sel == '0) begin
        x_d[bus.wr_slot]       = bus.wr_data[COORD_W-1:0];
        y_d[bus.wr_slot]       = bus.wr_data[2*COORD_W-1:COORD_W];
        pal_idx_d[bus.wr_slot] = bus.wr_data[2*COORD_W+PAL_W-1:2*COORD_W];
        en_d[bus.wr_slot]      = bus.wr_data[2*COORD_W+PAL_W];
        mode_d[bus.wr_slot]    = bus.wr_data[2*COORD_W+PAL_W+1];
      end else if (32'(bus.wr_sel) <= SPR_SIZE) begin
        bmp_d[bus.wr_slot][OFF_W'(bus.wr_sel - SEL_W'(1))] = bus.wr_data[SPR_SIZE-1:0];
      end else begin
        bmp_d = bmp_q;
      end
    end else begin
      bmp_d = bmp_q;
    end
    if (bus.att_color) begin
      pal_d[bus.pal_addr] = bus.data_color;
    end else begin
      pal_d = pal_q;
    end
  end

  // Stage 1: window test in COORD_W+1 bits so x+SPR_SIZE cannot wrap, then bitmap lookup
  always_comb begin
    col_in = 1'b0; row_in = 1'b0; dx = '0; dy = '0; hit_d = '0;
    for (int s = 0; s < N_SPRITES; s++) begin
      col_in = ({1'b0, bus.column} >= {1'b0, x_q[s]}) &&
               ({1'b0, bus.column} < ({1'b0, x_q[s]} + CW1'(SPR_SIZE)));
      row_in = ({1'b0, bus.row} >= {1'b0, y_q[s]}) &&
               ({1'b0, bus.row} < ({1'b0, y_q[s]} + CW1'(SPR_SIZE)));
      dx = OFF_W'(bus.column - x_q[s]);
      dy = OFF_W'(bus.row - y_q[s]);
      // SPR_SIZE is a power of two, so SPR_SIZE-1-dx is simply ~dx (MSB = leftmost)
      hit_d[s] = en_q[s] & col_in & row_in & bmp_q[s][dy][~dx];
    end
    bg1_d = {bus.FIFO_Red, bus.FIFO_Green, bus.FIFO_Blue};
    v1_d  = bus.pix_valid;
  end

  // Stage 2: lowest-index winner, sticky collision (new overlap beats clear)
  always_comb begin
    pal2_d = '0; mode2_d = 1'b0;
    for (int s = N_SPRITES - 1; s >= 0; s--) begin
      if (hit_q[s]) begin
        pal2_d  = pal_idx_q[s];
        mode2_d = mode_q[s];
      end else begin
        pal2_d  = pal2_d;
      end
    end
    any2_d = |hit_q;
    bg2_d  = bg1_q;
    v2_d   = v1_q;
    // Two or more bits set iff clearing the lowest set bit leaves something
    multi  = (hit_q & (hit_q - N_SPRITES'(1))) != '0;
    if (bus.coll_clr) begin
      collision_d = '0;
    end else begin
      collision_d = collision_q;
    end
    if (v1_q && multi) begin
      collision_d = collision_d | hit_q;
    end else begin
      collision_d = collision_d;
    end
  end

  // Stage 3: palette read, opaque or 50 % blend, hold on bubbles
  always_comb begin
    pal_rgb     = pal_q[pal2_q];
    out_valid_d = v2_q;
    rgb_d       = rgb_q;
    if (v2_q) begin
      if (!any2_q) begin
        rgb_d = bg2_q;
      end else if (!mode2_q) begin
        rgb_d = pal_rgb;
      end else begin
        rgb_d = {avg(pal_rgb[RGB_W-1 -: COLOR_W],   bg2_q[RGB_W-1 -: COLOR_W]),
                 avg(pal_rgb[2*COLOR_W-1 -: COLOR_W], bg2_q[2*COLOR_W-1 -: COLOR_W]),
                 avg(pal_rgb[COLOR_W-1:0],          bg2_q[COLOR_W-1:0])};
      end
    end else begin
      rgb_d = rgb_q;
    end
  end

  // All state: asynchronous clear, otherwise load next-state values
  always_ff @(posedge clk_25 or negedge n_reset) begin
    if (!n_reset) begin
      x_q <= '0; y_q <= '0; pal_idx_q <= '0; en_q <= '0; mode_q <= '0;
      bmp_q <= '0; pal_q <= '0;
      hit_q <= '0; bg1_q <= '0; v1_q <= 1'b0;
      pal2_q <= '0; mode2_q <= 1'b0; any2_q <= 1'b0; bg2_q <= '0; v2_q <= 1'b0;
      collision_q <= '0; rgb_q <= '0; out_valid_q <= 1'b0;
    end else begin
      x_q <= x_d; y_q <= y_d; pal_idx_q <= pal_idx_d; en_q <= en_d; mode_q <= mode_d;
      bmp_q <= bmp_d; pal_q <= pal_d;
      hit_q <= hit_d; bg1_q <= bg1_d; v1_q <= v1_d;
      pal2_q <= pal2_d; mode2_q <= mode2_d; any2_q <= any2_d; bg2_q <= bg2_d; v2_q <= v2_d;
      collision_q <= collision_d; rgb_q <= rgb_d; out_valid_q <= out_valid_d;
    end
  end

  assign bus.VGA_R     = rgb_q[RGB_W-1 -: COLOR_W];
  assign bus.VGA_G     = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign bus.VGA_B     = rgb_q[COLOR_W-1:0];
  assign bus.out_valid = out_valid_q;
  assign bus.collision = collision_q;
endmodule

// File: tb/tb_sprite_compositor_n.sv
// Scoreboard bench for sprite_compositor_n: a behavioural model predicts each
// pixel when it is driven; a monitor compares on every out_valid.
module tb_sprite_compositor_n;
  logic clk_25;
  logic n_reset;
  int   n_chk;
  int   n_fail;

  sprite_compositor_n_if #(.N_SPRITES(8), .SPR_SIZE(16), .COORD_W(10),
                           .PAL_DEPTH(16), .COLOR_W(8)) bus ();

  sprite_compositor_n #(.N_SPRITES(8), .SPR_SIZE(16), .COORD_W(10),
                        .PAL_DEPTH(16), .COLOR_W(8)) dut (
    .clk_25 (clk_25),
    .n_reset(n_reset),
    .bus    (bus)
  );

  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;

  // Model state
  int          m_x[8];
  int          m_y[8];
  int          m_pi[8];
  bit          m_en[8];
  bit          m_mode[8];
  logic [15:0] m_bmp[8][16];
  logic [23:0] m_pal[16];
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  logic [23:0] last_e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_x[s] = 0; m_y[s] = 0; m_pi[s] = 0; m_en[s] = 1'b0; m_mode[s] = 1'b0;
      for (int r = 0; r < 16; r++) m_bmp[s][r] = 16'h0000;
    end
    for (int p = 0; p < 16; p++) m_pal[p] = 24'h000000;
  endtask

  task automatic model_pix(input int r, input int c, input logic [23:0] bg,
                           output logic [23:0] e);
    int win;
    logic [23:0] p;
    win = -1;
    for (int s = 0; s < 8; s++) begin
      if (m_en[s] && c >= m_x[s] && c < m_x[s] + 16 && r >= m_y[s] && r < m_y[s] + 16 &&
          m_bmp[s][r - m_y[s]][15 - (c - m_x[s])] && win < 0)
        win = s;
    end
    if (win < 0) e = bg;
    else begin
      p = m_pal[m_pi[win]];
      if (!m_mode[win]) e = p;
      else begin
        e[23:16] = 8'((int'(p[23:16]) + int'(bg[23:16])) / 2);
        e[15:8]  = 8'((int'(p[15:8])  + int'(bg[15:8]))  / 2);
        e[7:0]   = 8'((int'(p[7:0])   + int'(bg[7:0]))   / 2);
      end
    end
  endtask

  // One clock of stimulus; any write fields set by the caller apply this cycle
  task automatic cyc(input bit pv, input int r, input int c, input logic [23:0] bg,
                     input bit clr);
    logic [23:0] e;
    bus.pix_valid = pv;
    bus.row = 10'(r);
    bus.column = 10'(c);
    {bus.FIFO_Red, bus.FIFO_Green, bus.FIFO_Blue} = bg;
    bus.coll_clr = clr;
    model_pix(r, c, bg, e);
    if (pv) exp_q.push_back(e);
    @(posedge clk_25); #1;
    bus.wr_en = 1'b0; bus.att_color = 1'b0; bus.coll_clr = 1'b0; bus.pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 24'h0, 1'b0);
  endtask

  task automatic wr_attr(input int s, input int x, input int y, input int p,
                         input bit en, input bit mode);
    bus.wr_en = 1'b1; bus.wr_slot = 3'(s); bus.wr_sel = 5'd0;
    bus.wr_data = {mode, en, 4'(p), 10'(y), 10'(x)};
    m_x[s] = x; m_y[s] = y; m_pi[s] = p; m_en[s] = en; m_mode[s] = mode;
    cyc(1'b0, 0, 0, 24'h0, 1'b0);
  endtask

  task automatic wr_row(input int s, input int r, input logic [15:0] bits);
    bus.wr_en = 1'b1; bus.wr_slot = 3'(s); bus.wr_sel = 5'(r + 1);
    bus.wr_data = 26'(bits);
    m_bmp[s][r] = bits;
    cyc(1'b0, 0, 0, 24'h0, 1'b0);
  endtask

  task automatic wr_pal(input int a, input logic [23:0] col);
    bus.att_color = 1'b1; bus.pal_addr = 4'(a); bus.data_color = col;
    m_pal[a] = col;
    cyc(1'b0, 0, 0, 24'h0, 1'b0);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk_25) begin
    if (bus.out_valid) begin
      if (exp_q.size() == 0) chk("extra_out", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        last_e = mon_e;
        chk("pix", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h0, mon_e});
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0;
    last_e = 24'h0;
    model_reset();
    bus.wr_en = 1'b0; bus.wr_slot = 3'd0; bus.wr_sel = 5'd0; bus.wr_data = 26'd0;
    bus.att_color = 1'b0; bus.pal_addr = 4'd0; bus.data_color = 24'd0;
    bus.coll_clr = 1'b0; bus.pix_valid = 1'b0; bus.row = 10'd0; bus.column = 10'd0;
    bus.FIFO_Red = 8'd0; bus.FIFO_Green = 8'd0; bus.FIFO_Blue = 8'd0;
    n_reset = 1'b0;
    #3;
    chk("rst_rgb", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'h0);
    chk("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_coll", {24'h0, bus.collision}, 32'h0);
    @(posedge clk_25); #1;
    n_reset = 1'b1;

    // Plain background passes through
    cyc(1'b1, 0, 5, 24'h102030, 1'b0);
    idle(4);

    // Slot 0 edge columns and rows
    wr_pal(3, 24'hFF0000);
    wr_attr(0, 100, 50, 3, 1'b1, 1'b0);
    wr_row(0, 0, 16'h8001);
    cyc(1'b1, 50, 100, 24'h0A0B0C, 1'b0);
    cyc(1'b1, 50, 101, 24'h0A0B0D, 1'b0);
    cyc(1'b1, 50, 115, 24'h0A0B0E, 1'b0);
    cyc(1'b1, 50, 116, 24'h0A0B0F, 1'b0);
    cyc(1'b1, 49, 100, 24'h0A0B10, 1'b0);
    idle(4);

    // Overlapping slots 2 and 5, collision flags
    wr_pal(5, 24'h00FF00);
    wr_pal(6, 24'h0000FF);
    wr_attr(2, 200, 200, 5, 1'b1, 1'b0);
    wr_attr(5, 208, 204, 6, 1'b1, 1'b0);
    for (int r = 0; r < 16; r++) begin
      wr_row(2, r, 16'hFFFF);
      wr_row(5, r, 16'hFFFF);
    end
    cyc(1'b0, 205, 210, 24'h111111, 1'b0);
    idle(4);
    chk("coll_invalid", {24'h0, bus.collision}, 32'h0);
    cyc(1'b1, 205, 210, 24'h111111, 1'b0);
    cyc(1'b1, 200, 200, 24'h222222, 1'b0);
    cyc(1'b1, 219, 223, 24'h333333, 1'b0);
    idle(4);
    chk("coll_set", {24'h0, bus.collision}, 32'h24);
    cyc(1'b1, 200, 200, 24'h222222, 1'b1);
    idle(4);
    chk("coll_clr", {24'h0, bus.collision}, 32'h0);
    cyc(1'b1, 206, 209, 24'h444444, 1'b0);
    cyc(1'b1, 200, 201, 24'h555555, 1'b1);
    idle(4);
    chk("coll_clr_race", {24'h0, bus.collision}, 32'h24);

    // 50 % blend
    wr_pal(7, 24'hFF8000);
    wr_attr(1, 300, 300, 7, 1'b1, 1'b1);
    wr_row(1, 0, 16'hFFFF);
    cyc(1'b1, 300, 300, 24'h0180FF, 1'b0);
    cyc(1'b1, 300, 310, 24'h000000, 1'b0);
    idle(4);

    // Right-edge clipping and ignored out-of-range bitmap select
    wr_pal(8, 24'h123456);
    wr_attr(3, 1020, 0, 8, 1'b1, 1'b0);
    wr_row(3, 0, 16'hFFFF);
    for (int c = 1019; c < 1024; c++) cyc(1'b1, 0, c, 24'h0F0F0F, 1'b0);
    cyc(1'b1, 0, 0, 24'h0E0E0E, 1'b0);
    bus.wr_en = 1'b1; bus.wr_slot = 3'd3; bus.wr_sel = 5'd17; bus.wr_data = 26'd0;
    cyc(1'b0, 0, 0, 24'h0, 1'b0);
    cyc(1'b1, 0, 1020, 24'h0D0D0D, 1'b0);
    cyc(1'b1, 1, 1021, 24'h0C0C0C, 1'b0);
    idle(4);

    // Disable one cycle before the pixel
    wr_attr(0, 100, 50, 3, 1'b0, 1'b0);
    cyc(1'b1, 50, 100, 24'h445566, 1'b0);
    idle(4);
    chk("hold", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h0, last_e});

    // Asynchronous reset mid-stream
    cyc(1'b1, 200, 200, 24'h010101, 1'b0);
    idle(3);
    cyc(1'b1, 200, 201, 24'h020202, 1'b0);
    #1 n_reset = 1'b0;
    #1;
    chk("arst_rgb", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'h0);
    chk("arst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("arst_coll", {24'h0, bus.collision}, 32'h0);
    exp_q.delete();
    model_reset();
    #1 n_reset = 1'b1;
    wr_attr(0, 100, 50, 3, 1'b1, 1'b0);
    wr_row(0, 0, 16'h8001);
    cyc(1'b1, 50, 100, 24'h112233, 1'b0);
    cyc(1'b1, 200, 200, 24'h445566, 1'b0);
    idle(5);

    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
